// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes from the ALU control decoder and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b110;
  localparam logic [2:0] ALU_RELU = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_iterative_mul_iter.sv
// Radix-2 shift-add multiplier datapath: one multiplier bit per step, fixed WIDTH steps.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  // Accumulator value after the current step; the top registers this on the final step.
  assign sum_o  = mplier[0] ? (acc + mcand) : acc;
  assign last_o = (cnt == CW'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (clear_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load_i) begin
      mcand  <= a_i;
      mplier <= b_i;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (step_i) begin
      acc    <= sum_o;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle add/sub/and/or/relu plus an iterative multiply that stalls via busy_o.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             done_o,
  output logic             busy_o
);

  alu_state_t       state, state_next;
  logic [WIDTH-1:0] alu_comb;
  logic [WIDTH-1:0] res_next;
  logic             res_we;
  logic             mul_load, mul_step, mul_clear, mul_last;
  logic [WIDTH-1:0] mul_sum;

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (mul_load),
    .step_i  (mul_step),
    .clear_i (mul_clear),
    .a_i     (data1_i),
    .b_i     (data2_i),
    .sum_o   (mul_sum),
    .last_o  (mul_last)
  );

  // Unlisted codes (000, 101) fall through to add.
  always_comb begin
    alu_comb = data1_i + data2_i;
    case (ALUCtrl_i)
      ALU_SUB:  alu_comb = data1_i - data2_i;
      ALU_AND:  alu_comb = data1_i & data2_i;
      ALU_OR:   alu_comb = data1_i | data2_i;
      ALU_RELU: alu_comb = data1_i[WIDTH-1] ? '0 : data1_i;
      default:  alu_comb = data1_i + data2_i;
    endcase
  end

  always_comb begin
    state_next = state;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    mul_clear  = 1'b0;
    res_we     = 1'b0;
    res_next   = alu_comb;
    case (state)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          if (ALUCtrl_i == ALU_MUL) begin
            mul_load   = 1'b1;
            state_next = ST_MUL;
          end else begin
            res_we = 1'b1;
          end
        end
      end
      ST_MUL: begin
        // Abort takes priority even on the final step, so no done is produced.
        if (abort_i) begin
          mul_clear  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          mul_step = 1'b1;
          if (mul_last) begin
            res_we     = 1'b1;
            res_next   = mul_sum;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      result_o <= '0;
      zero_o   <= 1'b1;
      done_o   <= 1'b0;
    end else begin
      state  <= state_next;
      done_o <= res_we;
      if (res_we) begin
        result_o <= res_next;
        zero_o   <= (res_next == '0);
      end
    end
  end

  assign busy_o = (state == ST_MUL);

endmodule
